// File: rtl/vga_seg_pkg.sv
// Shared definitions for the seven-segment text renderer.
//   glyph_t      : glyph index (hex digits, minus sign, blank)
//   SEG_*        : seg codes {g,f,e,d,c,b,a,dp}, dp bit shown cleared
//   seg_decode   : seg code -> glyph index (dp ignored, unknown -> blank)
//   seg_known    : code is one of the recognised patterns (or blank)
//   glyph_segs   : glyph index -> lit segments {g,f,e,d,c,b,a}
// The glyph bitmaps are drawn from the segment set of each glyph, so every
// glyph looks exactly like the seven-segment pattern it came from.
package vga_seg_pkg;

    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 32;

    typedef enum logic [4:0] {
        G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7,
        G_8, G_9, G_A, G_B, G_C, G_D, G_E, G_F,
        G_NEG, G_BLANK
    } glyph_t;

    localparam logic [7:0] SEG_0     = 8'h7E;
    localparam logic [7:0] SEG_1     = 8'h0C;
    localparam logic [7:0] SEG_2     = 8'hB6;
    localparam logic [7:0] SEG_3     = 8'h9E;
    localparam logic [7:0] SEG_4     = 8'hCC;
    localparam logic [7:0] SEG_5     = 8'hDA;
    localparam logic [7:0] SEG_6     = 8'hFA;
    localparam logic [7:0] SEG_7     = 8'h0E;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hDE;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'hF8;
    localparam logic [7:0] SEG_C     = 8'h72;
    localparam logic [7:0] SEG_D     = 8'hBC;
    localparam logic [7:0] SEG_E     = 8'hF2;
    localparam logic [7:0] SEG_F     = 8'hE2;
    localparam logic [7:0] SEG_NEG   = 8'h80;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic glyph_t seg_decode(input logic [7:0] code);
        case ({code[7:1], 1'b0})
            SEG_0:   return G_0;
            SEG_1:   return G_1;
            SEG_2:   return G_2;
            SEG_3:   return G_3;
            SEG_4:   return G_4;
            SEG_5:   return G_5;
            SEG_6:   return G_6;
            SEG_7:   return G_7;
            SEG_8:   return G_8;
            SEG_9:   return G_9;
            SEG_A:   return G_A;
            SEG_B:   return G_B;
            SEG_C:   return G_C;
            SEG_D:   return G_D;
            SEG_E:   return G_E;
            SEG_F:   return G_F;
            SEG_NEG: return G_NEG;
            default: return G_BLANK;
        endcase
    endfunction

    function automatic logic seg_known(input logic [7:0] code);
        return (code[7:1] == 7'd0) || (seg_decode(code) != G_BLANK);
    endfunction

    function automatic logic [6:0] glyph_segs(input glyph_t g);
        case (g)
            G_0:     return SEG_0[7:1];
            G_1:     return SEG_1[7:1];
            G_2:     return SEG_2[7:1];
            G_3:     return SEG_3[7:1];
            G_4:     return SEG_4[7:1];
            G_5:     return SEG_5[7:1];
            G_6:     return SEG_6[7:1];
            G_7:     return SEG_7[7:1];
            G_8:     return SEG_8[7:1];
            G_9:     return SEG_9[7:1];
            G_A:     return SEG_A[7:1];
            G_B:     return SEG_B[7:1];
            G_C:     return SEG_C[7:1];
            G_D:     return SEG_D[7:1];
            G_E:     return SEG_E[7:1];
            G_F:     return SEG_F[7:1];
            G_NEG:   return SEG_NEG[7:1];
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vga_glyph_rom.sv
// 32x32 glyph row ROM, one-cycle registered read.
//   clk   : clock
//   glyph : glyph index
//   row   : glyph row 0..31
//   bits  : row bitmap, bit 31 = leftmost column
// Segment strokes (rows / cols inclusive):
//   a r2-5 c8-23, b r4-15 c24-27, c r16-27 c24-27, d r26-29 c8-23,
//   e r16-27 c4-7, f r4-15 c4-7, g r14-17 c8-23
module vga_glyph_rom
    import vga_seg_pkg::*;
(
    input  logic               clk,
    input  glyph_t             glyph,
    input  logic [4:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= lo && i <= hi) m[31-i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic rows_in(input logic [4:0] r, input logic [4:0] lo,
                                     input logic [4:0] hi);
        return (r >= lo) && (r <= hi);
    endfunction

    logic [6:0]  segs;
    logic [31:0] row_bits;

    always_comb begin
        segs     = glyph_segs(glyph);
        row_bits = '0;
        if (segs[0] && rows_in(row, 5'd2,  5'd5))  row_bits = row_bits | span(8, 23);
        if (segs[1] && rows_in(row, 5'd4,  5'd15)) row_bits = row_bits | span(24, 27);
        if (segs[2] && rows_in(row, 5'd16, 5'd27)) row_bits = row_bits | span(24, 27);
        if (segs[3] && rows_in(row, 5'd26, 5'd29)) row_bits = row_bits | span(8, 23);
        if (segs[4] && rows_in(row, 5'd16, 5'd27)) row_bits = row_bits | span(4, 7);
        if (segs[5] && rows_in(row, 5'd4,  5'd15)) row_bits = row_bits | span(4, 7);
        if (segs[6] && rows_in(row, 5'd14, 5'd17)) row_bits = row_bits | span(8, 23);
    end

    always_ff @(posedge clk) begin
        bits <= row_bits;
    end

endmodule

// File: rtl/vga_seg_text_renderer.sv
// Renders a row of seven-segment codes as 32x32 glyphs on the VGA raster.
// Digit codes are written into a shadow bank and copied to the active bank
// on frame_start, so a frame never shows a half-updated row.
// Optional feature macro: VGA_SEG_BLINK_EN (per-digit blink from a 6-bit
// frame counter; without it blink_mask is ignored).
// Ports:
//   clk, rst              clock, async active-high reset
//   wr_en/wr_idx/wr_seg   shadow bank write
//   frame_start           copy shadow -> active (start of vblank)
//   blink_mask            per-digit blink enable
//   pix_valid/pix_x/pix_y raster position in
//   out_valid/pix_on/pix_rgb  pixel result, 2 cycles after the input
//   bad_code              sticky: an unrecognised code reached the active bank
module vga_seg_text_renderer
    import vga_seg_pkg::*;
#(
    parameter int          NUM_DIGITS = 8,
    parameter int          X_W        = 10,
    parameter int          Y_W        = 10,
    parameter int          ORIGIN_X   = 64,
    parameter int          ORIGIN_Y   = 200,
    parameter int          SCALE_LOG2 = 0,
    parameter int          CELL_LOG2  = 6,
    parameter logic [11:0] FG_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] wr_idx,
    input  logic [7:0]            wr_seg,
    input  logic                  frame_start,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic                  pix_valid,
    input  logic [X_W-1:0]        pix_x,
    input  logic [Y_W-1:0]        pix_y,
    output logic                  out_valid,
    output logic                  pix_on,
    output logic [11:0]           pix_rgb,
    output logic                  bad_code
);

    localparam logic [X_W-1:0] OX = X_W'(ORIGIN_X);
    localparam logic [Y_W-1:0] OY = Y_W'(ORIGIN_Y);
    localparam logic [X_W-1:0] ND = X_W'(NUM_DIGITS);

    logic [7:0] shadow [NUM_DIGITS];
    logic [7:0] active [NUM_DIGITS];
    logic       shadow_bad;

    // A swap uses the shadow contents from before any same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
            end
            if (wr_en && (32'(wr_idx) < NUM_DIGITS)) shadow[wr_idx] <= wr_seg;
        end
    end

    always_comb begin
        shadow_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_bad = shadow_bad | ~seg_known(shadow[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            bad_code <= 1'b0;
        else if (frame_start && shadow_bad) bad_code <= 1'b1;
    end

    // ---- S1: cell geometry and active-bank sample ----
    logic [X_W-1:0]       dx, digit;
    logic [Y_W-1:0]       dy, row_full;
    logic [CELL_LOG2-1:0] col_full;
    logic                 in_box;
    logic [7:0]           code_sel;
    logic                 blank_s1;

    always_comb begin
        dx       = pix_x - OX;
        dy       = pix_y - OY;
        digit    = dx >> CELL_LOG2;
        col_full = dx[CELL_LOG2-1:0] >> SCALE_LOG2;
        row_full = dy >> SCALE_LOG2;
        // The >= checks reject pixels whose subtraction wrapped around.
        in_box   = (pix_x >= OX) && (pix_y >= OY) && (digit < ND) &&
                   ((col_full >> 5) == '0) && ((row_full >> 5) == '0);
        code_sel = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit == X_W'(i)) code_sel = active[i];
        end
    end

`ifdef VGA_SEG_BLINK_EN
    logic [5:0] frame_cnt;
    logic       blink_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              frame_cnt <= 6'd0;
        else if (frame_start) frame_cnt <= frame_cnt + 6'd1;
    end

    always_comb begin
        blink_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit == X_W'(i)) blink_sel = blink_mask[i];
        end
        blank_s1 = blink_sel & frame_cnt[5];
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blank_s1     = 1'b0;
`endif

    logic       vld_p1, vld_p2;
    logic       in_box_p1, in_box_p2;
    logic       blank_p1, blank_p2;
    logic [4:0] col_p1, col_p2, row_p1;
    glyph_t     glyph_p1;
    logic [31:0] bits_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        in_box_p1 <= in_box;
        col_p1    <= col_full[4:0];
        row_p1    <= row_full[4:0];
        glyph_p1  <= seg_decode(code_sel);
        blank_p1  <= blank_s1;
    end

    // ---- S2: glyph row lookup ----
    vga_glyph_rom u_rom (
        .clk   (clk),
        .glyph (glyph_p1),
        .row   (row_p1),
        .bits  (bits_p2)
    );

    always_ff @(posedge clk) begin
        in_box_p2 <= in_box_p1;
        col_p2    <= col_p1;
        blank_p2  <= blank_p1;
    end

    assign out_valid = vld_p2;
    assign pix_on    = vld_p2 & in_box_p2 & bits_p2[5'd31 - col_p2] & ~blank_p2;
    assign pix_rgb   = !vld_p2 ? 12'h000 : (pix_on ? FG_RGB : BG_RGB);

endmodule

// File: tb/tb_vga_seg_text_renderer.sv
module tb_vga_seg_text_renderer;

    localparam int N    = 8;
    localparam int OX   = 64;
    localparam int OY   = 200;
    localparam int S    = 0;
    localparam int CL   = 6;
    localparam int CELL = 1 << CL;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
`ifdef VGA_SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_idx = '0;
    logic [7:0]   wr_seg = '0;
    logic         frame_start = 1'b0;
    logic [N-1:0] blink_mask = '0;
    logic         pix_valid = 1'b0;
    logic [9:0]   pix_x = '0;
    logic [9:0]   pix_y = '0;
    logic         out_valid, pix_on, bad_code;
    logic [11:0]  pix_rgb;

    always #5 clk = ~clk;

    vga_seg_text_renderer #(
        .NUM_DIGITS(N), .X_W(10), .Y_W(10), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .SCALE_LOG2(S), .CELL_LOG2(CL), .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_seg(wr_seg),
        .frame_start(frame_start), .blink_mask(blink_mask), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .out_valid(out_valid), .pix_on(pix_on),
        .pix_rgb(pix_rgb), .bad_code(bad_code)
    );

    typedef struct {
        logic        v;
        logic        on;
        logic [11:0] rgb;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_shadow [N];
    logic [7:0] m_active [N];
    logic       m_bad;
    logic [5:0] m_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Recognised codes light exactly their own segments; anything else is blank.
    function automatic logic [6:0] m_segs(input logic [7:0] code);
        logic [7:0] c;
        c = code & 8'hFE;
        case (c)
            8'h7E, 8'h0C, 8'hB6, 8'h9E, 8'hCC, 8'hDA, 8'hFA, 8'h0E,
            8'hFE, 8'hDE, 8'hEE, 8'hF8, 8'h72, 8'hBC, 8'hF2, 8'hE2,
            8'h80:   return c[7:1];
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic m_known(input logic [7:0] code);
        return ((code & 8'hFE) == 8'h00) || (m_segs(code) != 7'd0);
    endfunction

    function automatic logic seg_lit(input logic [6:0] sg, input int c, input int r);
        if (sg[0] && r >= 2  && r <= 5  && c >= 8  && c <= 23) return 1'b1;
        if (sg[1] && r >= 4  && r <= 15 && c >= 24 && c <= 27) return 1'b1;
        if (sg[2] && r >= 16 && r <= 27 && c >= 24 && c <= 27) return 1'b1;
        if (sg[3] && r >= 26 && r <= 29 && c >= 8  && c <= 23) return 1'b1;
        if (sg[4] && r >= 16 && r <= 27 && c >= 4  && c <= 7)  return 1'b1;
        if (sg[5] && r >= 4  && r <= 15 && c >= 4  && c <= 7)  return 1'b1;
        if (sg[6] && r >= 14 && r <= 17 && c >= 8  && c <= 23) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_pix(input int x, input int y);
        int dx, dy, d, c, r;
        if (x < OX || y < OY) return 1'b0;
        dx = x - OX;
        dy = y - OY;
        d  = dx / CELL;
        if (d >= N) return 1'b0;
        c = (dx % CELL) >> S;
        r = dy >> S;
        if (c >= 32 || r >= 32) return 1'b0;
        if (BLINK && blink_mask[d] && m_cnt[5]) return 1'b0;
        return seg_lit(m_segs(m_active[d]), c, r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_bad = 1'b0;
        m_cnt = 6'd0;
        q.delete();
    endtask

    // One clock: queue the expectation for the current pixel, advance the
    // model, and compare whatever the DUT completes on this edge.
    task automatic tick();
        exp_t e;
        e.v   = pix_valid;
        e.on  = pix_valid && m_pix(int'(pix_x), int'(pix_y));
        e.rgb = !pix_valid ? 12'h000 : (e.on ? FG : BG);
        q.push_back(e);
        if (frame_start) begin
            for (int i = 0; i < N; i++) begin
                if (!m_known(m_shadow[i])) m_bad = 1'b1;
                m_active[i] = m_shadow[i];
            end
            m_cnt = m_cnt + 6'd1;
        end
        if (wr_en && int'(wr_idx) < N) m_shadow[wr_idx] = wr_seg;
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("out_valid", 32'(out_valid), 32'(e.v));
            check("pix_on",    32'(pix_on),    32'(e.on));
            check("pix_rgb",   32'(pix_rgb),   32'(e.rgb));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input int x, input int y);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [7:0] seg, input logic fs);
        wr_en       = 1'b1;
        wr_idx      = 3'(idx);
        wr_seg      = seg;
        frame_start = fs;
        tick();
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    logic [7:0] codes [18] = '{8'h7E, 8'h0C, 8'hB6, 8'h9E, 8'hCC, 8'hDA, 8'hFA, 8'h0E,
                               8'hFE, 8'hDE, 8'hEE, 8'hF8, 8'h72, 8'hBC, 8'hF2, 8'hE2,
                               8'h80, 8'h00};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pix_on",    32'(pix_on),    32'd0);
        check("rst_pix_rgb",   32'(pix_rgb),   32'd0);
        check("rst_bad_code",  32'(bad_code),  32'd0);
        rst = 1'b0;
        idle(2);

        // digit 0 = '1': right stroke lit, top bar not
        wr(0, 8'h0C, 1'b0);
        fs();
        pix(OX + 25, OY + 8);
        pix(OX + 12, OY + 3);
        pix(OX + 25, OY + 20);
        idle(2);

        // digit 1 = 'A' written, shown only after the swap
        wr(1, 8'hEE, 1'b0);
        pix(OX + CELL + 12, OY + 3);
        fs();
        pix(OX + CELL + 12, OY + 3);
        pix(OX + CELL + 12, OY + 28);
        idle(2);

        // digit 2: '7' this frame, '2' written in the swap cycle
        wr(2, 8'h0E, 1'b0);
        fs();
        wr(2, 8'hB6, 1'b1);
        pix(2*CELL + OX + 5, OY + 20);
        pix(2*CELL + OX + 25, OY + 20);
        fs();
        pix(2*CELL + OX + 5, OY + 20);
        pix(2*CELL + OX + 25, OY + 20);
        idle(2);

        // outside the row of digits
        wr(7, 8'hFE, 1'b0);
        fs();
        pix(OX - 1, OY + 8);
        pix(OX + N*CELL, OY + 8);
        pix(OX + N*CELL - 5, OY + 8);
        pix(OX + 25, OY - 1);
        pix(OX + 25, OY + 32);
        idle(2);

        // unrecognised code: blank digit, sticky flag
        check("bad_code_before", 32'(bad_code), 32'(m_bad));
        wr(3, 8'h55, 1'b0);
        fs();
        pix(3*CELL + OX + 25, OY + 8);
        check("bad_code_set", 32'(bad_code), 32'(m_bad));
        fs();
        check("bad_code_sticky", 32'(bad_code), 32'(m_bad));
        wr(3, 8'h9F, 1'b0);
        fs();
        pix(3*CELL + OX + 25, OY + 20);
        idle(2);

        // randomised traffic against the model
        blink_mask = 8'(($urandom & 32'hFF));
        for (int i = 0; i < 400; i++) begin
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_idx      = 3'($urandom_range(0, N - 1));
            wr_seg      = ($urandom_range(0, 7) == 0) ? 8'($urandom) :
                          (codes[$urandom_range(0, 17)] | 8'($urandom_range(0, 1)));
            frame_start = ($urandom_range(0, 15) == 0);
            pix_valid   = ($urandom_range(0, 3) != 0);
            pix_x       = 10'($urandom_range(OX - 8, OX + N*CELL + 8));
            pix_y       = 10'($urandom_range(OY - 4, OY + 36));
            tick();
        end
        wr_en = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        idle(2);
        check("bad_code_random", 32'(bad_code), 32'(m_bad));

        // reset in the middle of a row
        wr(4, 8'h55, 1'b0);
        fs();
        pix_valid = 1'b1; pix_x = 10'(OX + 25); pix_y = 10'(OY + 8);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_pix_on",    32'(pix_on),    32'd0);
        check("midrst_pix_rgb",   32'(pix_rgb),   32'd0);
        check("midrst_bad_code",  32'(bad_code),  32'd0);
        pix_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix(OX + 25, OY + 8);
        idle(2);

        // blink: digit 0 shows '8', blink enabled on digit 0 only
        blink_mask = 8'h01;
        wr(0, 8'hFE, 1'b0);
        for (int f = 0; f < 66; f++) begin
            fs();
            pix(OX + 12, OY + 3);
            pix(CELL + OX + 12, OY + 3);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
